// File: rtl/spi_adc_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_adc_capture_if
//  Purpose  : Request, SPI pin and valid/ready word bundle for spi_adc_capture.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_adc_capture_if #(
    parameter int DATA_W = 16
) ();
    logic              sample;
    logic              MISO;
    logic              CS_b;
    logic              sclk;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              overrun;

    modport master (
        input  sample, MISO, data_ready,
        output CS_b, sclk, busy, data_out, data_valid, overrun
    );

    modport slave (
        output sample, MISO, data_ready,
        input  CS_b, sclk, busy, data_out, data_valid, overrun
    );
endinterface
`default_nettype wire

// File: rtl/spi_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : spi_adc_capture
//  Purpose  : SPI master receiver capturing one ADC frame per request into a
//             valid/ready output register with a one-deep pending request.
//  Revision : 1.0  initial release
// ============================================================================
module spi_adc_capture #(
    parameter int DATA_W      = 16,
    parameter int FRAME_BITS  = 16,
    parameter int HALF_DIV    = 2,
    parameter int CS_SETUP    = 1,
    parameter int CS_QUIET    = 2,
    parameter int SAMPLE_EDGE = 0,
    parameter int MSB_FIRST   = 1
) (
    input  wire logic           sysclk,
    input  wire logic           PRESET,
    spi_adc_capture_if.master   bus
);

    localparam int c_DIV_W    = (HALF_DIV   > 1) ? $clog2(HALF_DIV)   : 1;
    localparam int c_BIT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int c_WAIT_MAX = (CS_SETUP > CS_QUIET) ? CS_SETUP : CS_QUIET;
    localparam int c_WAIT_W   = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(HALF_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(FRAME_BITS - 1);
    localparam logic [c_WAIT_W-1:0] c_SETUP_LAST = c_WAIT_W'(CS_SETUP - 1);
    localparam logic [c_WAIT_W-1:0] c_QUIET_LAST = c_WAIT_W'(CS_QUIET - 1);
    localparam logic                c_CAP_FALL   = (SAMPLE_EDGE == 0);
    localparam logic                c_CAP_RISE   = (SAMPLE_EDGE != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_QUIET = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div,  w_div_nxt;
    logic [c_BIT_W-1:0]  r_bit,  w_bit_nxt;
    logic [c_WAIT_W-1:0] r_wait, w_wait_nxt;
    logic                r_cs_b, w_cs_b_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                w_capture;
    logic                w_done;
    logic                w_start;
    logic                w_drop;
    logic                r_busy;
    logic                r_pending;
    logic                r_valid;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_shreg_shifted;

    // Older bits fall off the far end, so only the last DATA_W of a frame survive.
    generate
        if (DATA_W == 1) begin : g_shift_w1
            assign w_shreg_shifted = bus.MISO;
        end else if (MSB_FIRST != 0) begin : g_shift_msb
            assign w_shreg_shifted = {r_shreg[DATA_W-2:0], bus.MISO};
        end else begin : g_shift_lsb
            assign w_shreg_shifted = {bus.MISO, r_shreg[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge sysclk or posedge PRESET) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_wait_nxt  = r_wait;
        w_cs_b_nxt  = r_cs_b;
        w_sclk_nxt  = r_sclk;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sample || r_pending) begin
                    w_state_nxt = S_SETUP;
                    w_cs_b_nxt  = 1'b0;
                    w_wait_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_wait == c_SETUP_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_sclk_nxt  = 1'b0;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_capture   = c_CAP_FALL;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_div == c_DIV_LAST) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                        w_capture  = c_CAP_RISE;
                    end else if (r_bit == c_BIT_LAST) begin
                        // Frame ends with sclk high; CS_b and the word update together.
                        w_state_nxt = S_QUIET;
                        w_cs_b_nxt  = 1'b1;
                        w_wait_nxt  = '0;
                        w_done      = 1'b1;
                    end else begin
                        w_bit_nxt  = r_bit + 1'b1;
                        w_sclk_nxt = 1'b0;
                        w_capture  = c_CAP_FALL;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            S_QUIET: begin
                if (r_wait == c_QUIET_LAST) w_state_nxt = S_IDLE;
                else                        w_wait_nxt  = r_wait + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_drop = bus.sample && (r_state != S_IDLE) && r_pending;

    always_ff @(posedge sysclk or posedge PRESET) begin
        if (PRESET) begin
            r_div     <= '0;
            r_bit     <= '0;
            r_wait    <= '0;
            r_cs_b    <= 1'b1;
            r_sclk    <= 1'b1;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_shreg   <= '0;
            r_data    <= '0;
        end else begin
            r_div  <= w_div_nxt;
            r_bit  <= w_bit_nxt;
            r_wait <= w_wait_nxt;
            r_cs_b <= w_cs_b_nxt;
            r_sclk <= w_sclk_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_capture) r_shreg <= w_shreg_shifted;

            // A request arriving in IDLE merges with any pending one into a single frame.
            if (w_start)
                r_pending <= 1'b0;
            else if (bus.sample && (r_state != S_IDLE))
                r_pending <= 1'b1;

            r_overrun <= w_drop || (w_done && r_valid && !bus.data_ready);

            if (w_done) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && bus.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.CS_b       = r_cs_b;
    assign bus.sclk       = r_sclk;
    assign bus.busy       = r_busy;
    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_adc_capture
//  Purpose  : Directed self-checking bench for spi_adc_capture.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_adc_capture;

    logic sysclk = 1'b0;
    logic PRESET;
    always #5 sysclk = ~sysclk;

    spi_adc_capture_if #(.DATA_W(16)) bus0 ();
    spi_adc_capture_if #(.DATA_W(16)) bus1 ();

    spi_adc_capture dut0 (
        .sysclk (sysclk),
        .PRESET (PRESET),
        .bus    (bus0)
    );

    spi_adc_capture #(
        .FRAME_BITS  (18),
        .SAMPLE_EDGE (1),
        .MSB_FIRST   (0)
    ) dut1 (
        .sysclk (sysclk),
        .PRESET (PRESET),
        .bus    (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] stream0 = '0;
    logic [31:0] stream1 = '0;
    int          idx0 = 0, idx1 = 0;
    logic        prev0 = 1'b1, prev1 = 1'b1;

    // ADC model: present stream bit idx, advance once the capture edge has been issued.
    always @(negedge sysclk) begin
        if (bus0.CS_b)              idx0 = 0;
        else if (prev0 && !bus0.sclk) idx0 = idx0 + 1;
        prev0 = bus0.sclk;
        bus0.MISO = stream0[idx0[4:0]];
        if (bus1.CS_b)              idx1 = 0;
        else if (!prev1 && bus1.sclk) idx1 = idx1 + 1;
        prev1 = bus1.sclk;
        bus1.MISO = stream1[idx1[4:0]];
    end

    int   cyc = 0;
    int   falls0 = 0, ovr0 = 0;
    int   last_fall0 = 0, last_rise0 = 0, prev_rise0 = 0, last_ovr0 = 0;
    logic mcs0 = 1'b1;

    always @(negedge sysclk) begin
        cyc = cyc + 1;
        if (mcs0 && !bus0.CS_b) begin
            falls0     = falls0 + 1;
            last_fall0 = cyc;
        end
        if (!mcs0 && bus0.CS_b) begin
            prev_rise0 = last_rise0;
            last_rise0 = cyc;
        end
        mcs0 = bus0.CS_b;
        if (bus0.overrun === 1'b1) begin
            ovr0      = ovr0 + 1;
            last_ovr0 = cyc;
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] msb_stream(input logic [15:0] w);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s[k] = w[15-k];
        return s;
    endfunction

    int   edges, lowcnt, nfall, lastf, bad_gap, c3, f_base, o_base, guard;
    logic ps;

    initial begin
        PRESET          = 1'b1;
        bus0.sample     = 1'b0;
        bus0.data_ready = 1'b1;
        bus1.sample     = 1'b0;
        bus1.data_ready = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_cs_b",  {31'd0, bus0.CS_b},       32'd1);
        check("rst_sclk",  {31'd0, bus0.sclk},       32'd1);
        check("rst_busy",  {31'd0, bus0.busy},       32'd0);
        check("rst_data",  {16'd0, bus0.data_out},   32'd0);
        check("rst_valid", {31'd0, bus0.data_valid}, 32'd0);
        check("rst_ovr",   {31'd0, bus0.overrun},    32'd0);
        PRESET = 1'b0;
        tick();
        tick();

        // ---- basic MSB-first frame, falling-edge capture ----
        stream0     = msb_stream(16'hA5C3);
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        check("t1_cs_fall", {31'd0, bus0.CS_b}, 32'd0);
        edges = 1; lowcnt = 1; nfall = 0; lastf = 0; bad_gap = 0; ps = bus0.sclk;
        while (bus0.CS_b == 1'b0 && edges < 200) begin
            tick();
            edges = edges + 1;
            if (ps && !bus0.sclk) begin
                nfall = nfall + 1;
                if (nfall > 1 && edges - lastf != 4) bad_gap = bad_gap + 1;
                lastf = edges;
            end
            ps = bus0.sclk;
            if (bus0.CS_b == 1'b0) lowcnt = lowcnt + 1;
        end
        check("t1_cs_low_cycles", lowcnt,  32'd65);
        check("t1_rise_edge",     edges,   32'd66);
        check("t1_sclk_falls",    nfall,   32'd16);
        check("t1_fall_spacing",  bad_gap, 32'd0);
        check("t1_data",  {16'd0, bus0.data_out},   32'h0000A5C3);
        check("t1_valid", {31'd0, bus0.data_valid}, 32'd1);
        check("t1_ovr",   {31'd0, bus0.overrun},    32'd0);
        tick();
        check("t1_consumed", {31'd0, bus0.data_valid}, 32'd0);

        // ---- 18-bit frame, rising-edge capture, LSB first ----
        stream1 = '0;
        stream1[1:0]  = 2'b11;
        stream1[17:2] = 16'h1234;
        bus1.sample = 1'b1;
        tick();
        bus1.sample = 1'b0;
        edges = 1;
        while (bus1.data_valid !== 1'b1 && edges < 300) begin
            tick();
            edges = edges + 1;
        end
        check("t2_word_edge", edges, 32'd74);
        check("t2_data", {16'd0, bus1.data_out}, 32'h00001234);
        check("t2_cs_b", {31'd0, bus1.CS_b},     32'd1);

        // ---- back-to-back frames with no consumer ----
        repeat (5) tick();
        o_base = ovr0;
        stream0 = msb_stream(16'h1111);
        bus0.data_ready = 1'b0;
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (5) tick();
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        guard = 0;
        while (bus0.data_valid !== 1'b1 && guard < 200) begin
            tick();
            guard = guard + 1;
        end
        check("t3_first_data", {16'd0, bus0.data_out}, 32'h00001111);
        check("t3_first_ovr",  {31'd0, bus0.overrun},  32'd0);
        stream0 = msb_stream(16'h2222);
        guard = 0;
        while (bus0.CS_b == 1'b1 && guard < 20) begin
            tick();
            guard = guard + 1;
        end
        while (bus0.CS_b == 1'b0 && guard < 200) begin
            tick();
            guard = guard + 1;
        end
        check("t3_second_data", {16'd0, bus0.data_out},   32'h00002222);
        check("t3_second_ovr",  {31'd0, bus0.overrun},    32'd1);
        check("t3_valid",       {31'd0, bus0.data_valid}, 32'd1);
        tick();
        check("t3_ovr_pulse_end", {31'd0, bus0.overrun}, 32'd0);
        check("t3_ovr_count", ovr0 - o_base, 32'd1);
        bus0.data_ready = 1'b1;
        tick();
        check("t3_drained", {31'd0, bus0.data_valid}, 32'd0);

        // ---- requests at cycles 0, 10, 20 ----
        repeat (5) tick();
        f_base = falls0;
        o_base = ovr0;
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (9) tick();
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (9) tick();
        bus0.sample = 1'b1;
        c3 = cyc;
        tick();
        bus0.sample = 1'b0;
        repeat (200) tick();
        check("t4_frames",     falls0 - f_base,         32'd2);
        check("t4_ovr_count",  ovr0 - o_base,           32'd1);
        check("t4_ovr_cycle",  last_ovr0 - c3,          32'd2);
        check("t4_quiet_gap",  last_fall0 - prev_rise0, 32'd3);

        // ---- reset mid-frame with a pending request ----
        repeat (5) tick();
        bus0.data_ready = 1'b0;
        stream0 = msb_stream(16'h5A5A);
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        guard = 0;
        while (bus0.data_valid !== 1'b1 && guard < 200) begin
            tick();
            guard = guard + 1;
        end
        check("t5_pre_valid", {31'd0, bus0.data_valid}, 32'd1);
        repeat (5) tick();
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (20) tick();
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (3) tick();
        check("t5_in_frame", {31'd0, bus0.CS_b}, 32'd0);
        #2;
        PRESET = 1'b1;
        #1;
        check("t5_cs_b",  {31'd0, bus0.CS_b},       32'd1);
        check("t5_sclk",  {31'd0, bus0.sclk},       32'd1);
        check("t5_valid", {31'd0, bus0.data_valid}, 32'd0);
        check("t5_busy",  {31'd0, bus0.busy},       32'd0);
        tick();
        PRESET = 1'b0;
        f_base = falls0;
        repeat (100) tick();
        check("t5_no_frame",   falls0 - f_base,    32'd0);
        check("t5_idle_busy",  {31'd0, bus0.busy}, 32'd0);

        // ---- transfer and load in the same cycle ----
        stream0 = msb_stream(16'h0F0F);
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        guard = 0;
        while (bus0.data_valid !== 1'b1 && guard < 200) begin
            tick();
            guard = guard + 1;
        end
        check("t6_first_data", {16'd0, bus0.data_out}, 32'h00000F0F);
        repeat (5) tick();
        stream0 = msb_stream(16'hBEEF);
        bus0.sample = 1'b1;
        tick();
        bus0.sample = 1'b0;
        repeat (64) tick();
        check("t6_held_valid", {31'd0, bus0.data_valid}, 32'd1);
        check("t6_held_data",  {16'd0, bus0.data_out},   32'h00000F0F);
        bus0.data_ready = 1'b1;
        tick();
        check("t6_valid", {31'd0, bus0.data_valid}, 32'd1);
        check("t6_data",  {16'd0, bus0.data_out},   32'h0000BEEF);
        check("t6_ovr",   {31'd0, bus0.overrun},    32'd0);
        tick();
        check("t6_drained", {31'd0, bus0.data_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
